dec_2of5_frame: RTL



---
 rtl/dec_2of5_frame_pkg.sv | 20 ++
 rtl/dec_2of5_digit.sv | 28 ++
 rtl/dec_2of5_frame.sv | 132 +++++++++++++
 3 files changed

// File: rtl/dec_2of5_frame_pkg.sv
// Shared constants for the 2-of-5 (two-hot) digit code: code words, invalid digit, frame FSM states.
package dec_2of5_frame_pkg;

  localparam logic [4:0] CODE_D0 = 5'b00011;
  localparam logic [4:0] CODE_D1 = 5'b00101;
  localparam logic [4:0] CODE_D2 = 5'b00110;
  localparam logic [4:0] CODE_D3 = 5'b01010;
  localparam logic [4:0] CODE_D4 = 5'b01001;
  localparam logic [4:0] CODE_D5 = 5'b01100;
  localparam logic [4:0] CODE_D6 = 5'b10100;
  localparam logic [4:0] CODE_D7 = 5'b10010;
  localparam logic [4:0] CODE_D8 = 5'b10001;
  localparam logic [4:0] CODE_D9 = 5'b11000;

  localparam logic [3:0] DIGIT_INVALID = 4'hF;

  localparam logic [0:0] ST_COLLECT = 1'b0;
  localparam logic [0:0] ST_HOLD    = 1'b1;

endpackage

// File: rtl/dec_2of5_digit.sv
// Combinational 2-of-5 code word to BCD digit lookup with invalid flag.
module dec_2of5_digit
  import dec_2of5_frame_pkg::*;
(
  input  logic [4:0] code,
  output logic [3:0] digit_c,
  output logic       invalid_c
);

  always_comb begin
    digit_c   = DIGIT_INVALID;
    invalid_c = 1'b0;
    case (code)
      CODE_D0: digit_c = 4'd0;
      CODE_D1: digit_c = 4'd1;
      CODE_D2: digit_c = 4'd2;
      CODE_D3: digit_c = 4'd3;
      CODE_D4: digit_c = 4'd4;
      CODE_D5: digit_c = 4'd5;
      CODE_D6: digit_c = 4'd6;
      CODE_D7: digit_c = 4'd7;
      CODE_D8: digit_c = 4'd8;
      CODE_D9: digit_c = 4'd9;
      default: invalid_c = 1'b1;
    endcase
  end

endmodule

// File: rtl/dec_2of5_frame.sv
// Assembles DIGITS decoded 2-of-5 words into a packed BCD frame with error flag and
// a saturating invalid-word counter.
module dec_2of5_frame
  import dec_2of5_frame_pkg::*;
#(
  parameter int unsigned DIGITS = 4,
  parameter int unsigned ECW    = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4:0]            in_code,
  input  logic                  in_valid,
  input  logic                  in_sof,
  output logic                  in_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ECW-1:0]        err_cnt,
  input  logic                  err_clr
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  logic [0:0]    state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [BW-1:0] asm_q, asm_d;
  logic          ferr_q, ferr_d;
  logic [BW-1:0] out_bcd_d;
  logic          out_err_d, out_valid_d, in_ready_d;
  logic [ECW-1:0] err_cnt_d;

  logic [3:0]    nib_c;
  logic          inv_c;
  logic          accept_c, resync_c;
  logic [BW-1:0] base_asm_c, shifted_c;
  logic [CW-1:0] base_cnt_c;
  logic          base_err_c;
  logic [BW+3:0] shift_ext_c;

  dec_2of5_digit u_digit (
    .code      (in_code),
    .digit_c   (nib_c),
    .invalid_c (inv_c)
  );

  assign accept_c = in_valid & in_ready;
  // An in_sof mid-frame restarts assembly with this word as the first digit.
  assign resync_c    = accept_c & in_sof & (count_q != '0);
  assign base_asm_c  = resync_c ? '0 : asm_q;
  assign base_cnt_c  = resync_c ? '0 : count_q;
  assign base_err_c  = resync_c | ferr_q;
  assign shift_ext_c = {base_asm_c, nib_c};
  assign shifted_c   = shift_ext_c[BW-1:0];

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    asm_d       = asm_q;
    ferr_d      = ferr_q;
    out_bcd_d   = out_bcd;
    out_err_d   = out_err;
    out_valid_d = out_valid;
    err_cnt_d   = err_cnt;

    case (state_q)
      ST_COLLECT: begin
        if (accept_c) begin
          if (base_cnt_c == CW'(DIGITS - 1)) begin
            out_bcd_d   = shifted_c;
            out_err_d   = base_err_c | inv_c;
            out_valid_d = 1'b1;
            state_d     = ST_HOLD;
            count_d     = '0;
            asm_d       = '0;
            ferr_d      = 1'b0;
          end else begin
            count_d = base_cnt_c + CW'(1);
            asm_d   = shifted_c;
            ferr_d  = base_err_c | inv_c;
          end
        end
      end
      ST_HOLD: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_COLLECT;
          count_d     = '0;
          asm_d       = '0;
          ferr_d      = 1'b0;
        end
      end
      default: state_d = ST_COLLECT;
    endcase

    in_ready_d = (state_d == ST_COLLECT);

    // Clear wins over a same-cycle increment; count holds at all-ones.
    if (err_clr) begin
      err_cnt_d = '0;
    end else if (accept_c && inv_c && (err_cnt != '1)) begin
      err_cnt_d = err_cnt + ECW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_COLLECT;
      count_q   <= '0;
      asm_q     <= '0;
      ferr_q    <= 1'b0;
      out_bcd   <= '0;
      out_err   <= 1'b0;
      out_valid <= 1'b0;
      in_ready  <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      asm_q     <= asm_d;
      ferr_q    <= ferr_d;
      out_bcd   <= out_bcd_d;
      out_err   <= out_err_d;
      out_valid <= out_valid_d;
      in_ready  <= in_ready_d;
      err_cnt   <= err_cnt_d;
    end
  end

endmodule
